// File: rtl/td4_pkg.sv
// Shared TD4 definitions: opcode values plus the source/destination selects
// that the execute core's decoder produces.
package td4_pkg;

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_AI = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_BI = 4'b0111;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_OUT_I  = 4'b1011;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  typedef enum logic [1:0] {
    SRC_A,
    SRC_B,
    SRC_IN,
    SRC_ZERO
  } src_sel_t;

  typedef enum logic [2:0] {
    DST_A,
    DST_B,
    DST_OUT,
    DST_PC,
    DST_NONE
  } dst_sel_t;

endpackage

// File: rtl/adder4.sv
// TD4 datapath adder: 4-bit sum with carry out.
module adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] s,
  output logic       c
);

  assign {c, s} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/td4_exec.sv
// TD4 single-cycle execute core: decodes the ROM word at pc, feeds the shared
// adder, and commits the result into A, B, out_port or pc plus the carry flag.
module td4_exec
  import td4_pkg::*;
(
  input  logic       clk,
  input  logic       n_reset,
  input  logic       en,
  input  logic [7:0] instr,
  input  logic [3:0] in_port,
  output logic [3:0] pc,
  output logic [3:0] out_port,
  output logic       carry,
  output logic [3:0] reg_a,
  output logic [3:0] reg_b
);

  logic [3:0] opcode;
  logic [3:0] imm;
  src_sel_t   src;
  dst_sel_t   dst;
  logic [3:0] add_a;
  logic [3:0] sum;
  logic       sum_c;
  logic       take_branch;

  assign opcode = instr[7:4];
  assign imm    = instr[3:0];

  // Unlisted opcodes fall through as NOPs: 0+Im into nowhere clears carry.
  always_comb begin
    src = SRC_ZERO;
    dst = DST_NONE;
    case (opcode)
      OP_ADD_A:  begin src = SRC_A;    dst = DST_A;   end
      OP_MOV_AB: begin src = SRC_B;    dst = DST_A;   end
      OP_IN_A:   begin src = SRC_IN;   dst = DST_A;   end
      OP_MOV_AI: begin src = SRC_ZERO; dst = DST_A;   end
      OP_MOV_BA: begin src = SRC_A;    dst = DST_B;   end
      OP_ADD_B:  begin src = SRC_B;    dst = DST_B;   end
      OP_IN_B:   begin src = SRC_IN;   dst = DST_B;   end
      OP_MOV_BI: begin src = SRC_ZERO; dst = DST_B;   end
      OP_OUT_B:  begin src = SRC_B;    dst = DST_OUT; end
      OP_OUT_I:  begin src = SRC_ZERO; dst = DST_OUT; end
      OP_JNC:    begin src = SRC_ZERO; dst = DST_PC;  end
      OP_JMP:    begin src = SRC_ZERO; dst = DST_PC;  end
      default:   begin src = SRC_ZERO; dst = DST_NONE; end
    endcase
  end

  always_comb begin
    add_a = 4'd0;
    case (src)
      SRC_A:   add_a = reg_a;
      SRC_B:   add_a = reg_b;
      SRC_IN:  add_a = in_port;
      default: add_a = 4'd0;
    endcase
  end

  adder4 u_adder (
    .a (add_a),
    .b (imm),
    .s (sum),
    .c (sum_c)
  );

  // JNC looks at the carry flag held before this edge.
  assign take_branch = (opcode == OP_JMP) || ((opcode == OP_JNC) && !carry);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      pc       <= 4'd0;
      reg_a    <= 4'd0;
      reg_b    <= 4'd0;
      out_port <= 4'd0;
      carry    <= 1'b0;
    end else if (en) begin
      carry <= sum_c;
      pc    <= pc + 4'd1;
      case (dst)
        DST_A:   reg_a    <= sum;
        DST_B:   reg_b    <= sum;
        DST_OUT: out_port <= sum;
        DST_PC:  if (take_branch) pc <= sum;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_td4_exec.sv
// Self-checking bench for td4_exec: directed ISA scenarios followed by random
// programs, all compared against an instruction-level reference model.
module tb_td4_exec;

  logic       clk = 1'b0;
  logic       n_reset;
  logic       en;
  logic [7:0] instr;
  logic [3:0] in_port;
  logic [3:0] pc;
  logic [3:0] out_port;
  logic       carry;
  logic [3:0] reg_a;
  logic [3:0] reg_b;

  logic [3:0] m_pc, m_a, m_b, m_out;
  logic       m_c;
  logic [7:0] rom [16];
  int         errors = 0;
  int         checks = 0;

  td4_exec dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .en       (en),
    .instr    (instr),
    .in_port  (in_port),
    .pc       (pc),
    .out_port (out_port),
    .carry    (carry),
    .reg_a    (reg_a),
    .reg_b    (reg_b)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_state(input string tag);
    checkOutput({tag, ".pc"},    {4'h0, pc},       {4'h0, m_pc});
    checkOutput({tag, ".a"},     {4'h0, reg_a},    {4'h0, m_a});
    checkOutput({tag, ".b"},     {4'h0, reg_b},    {4'h0, m_b});
    checkOutput({tag, ".out"},   {4'h0, out_port}, {4'h0, m_out});
    checkOutput({tag, ".carry"}, {7'h0, carry},    {7'h0, m_c});
  endtask

  task automatic model_reset();
    m_pc = 4'd0; m_a = 4'd0; m_b = 4'd0; m_out = 4'd0; m_c = 1'b0;
  endtask

  // Instruction-level reference: what each TD4 opcode does to the machine.
  task automatic model_exec(input logic [7:0] ins, input logic [3:0] inp);
    logic [3:0] op, im;
    logic [4:0] r;
    logic       old_c;
    op    = ins[7:4];
    im    = ins[3:0];
    old_c = m_c;
    r     = {1'b0, im};
    m_pc  = m_pc + 4'd1;
    case (op)
      4'h0: begin r = m_a + im;  m_a = r[3:0]; end
      4'h1: begin r = m_b + im;  m_a = r[3:0]; end
      4'h2: begin r = inp + im;  m_a = r[3:0]; end
      4'h3: begin                m_a = im;     end
      4'h4: begin r = m_a + im;  m_b = r[3:0]; end
      4'h5: begin r = m_b + im;  m_b = r[3:0]; end
      4'h6: begin r = inp + im;  m_b = r[3:0]; end
      4'h7: begin                m_b = im;     end
      4'h9: begin r = m_b + im;  m_out = r[3:0]; end
      4'hB: begin                m_out = im;   end
      4'hE: if (!old_c) m_pc = im;
      4'hF: m_pc = im;
      default: ;
    endcase
    m_c = r[4];
  endtask

  task automatic applyStimulus(input logic [7:0] ins, input logic [3:0] inp, input logic en_v, input string tag);
    instr   = ins;
    in_port = inp;
    en      = en_v;
    @(posedge clk);
    #1;
    if (en_v && n_reset) model_exec(ins, inp);
    check_state(tag);
  endtask

  task automatic async_reset(input string tag);
    #2;
    n_reset = 1'b0;
    #1;
    model_reset();
    check_state(tag);
    #1;
    n_reset = 1'b1;
  endtask

  initial begin
    n_reset = 1'b0;
    en      = 1'b1;
    instr   = 8'h3F;
    in_port = 4'h0;
    model_reset();
    #1;
    check_state("rst_async");
    for (int i = 0; i < 3; i++) applyStimulus(8'($urandom), 4'($urandom), 1'b1, "rst_hold");
    n_reset = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(8'h3F, 4'h0, 1'b0, "en_low");

    applyStimulus(8'h3F, 4'h0, 1'b1, "mov_a15");
    applyStimulus(8'h01, 4'h0, 1'b1, "add_a1");
    checkOutput("wrap_a",     {4'h0, reg_a}, 8'h00);
    checkOutput("wrap_carry", {7'h0, carry}, 8'h01);
    checkOutput("wrap_pc",    {4'h0, pc},    8'h02);
    applyStimulus(8'h02, 4'h0, 1'b1, "add_a2");
    checkOutput("add2_a", {4'h0, reg_a}, 8'h02);

    applyStimulus(8'h20, 4'h9, 1'b1, "in_a");
    applyStimulus(8'h40, 4'h0, 1'b1, "mov_ba");
    applyStimulus(8'h90, 4'h0, 1'b1, "out_b");
    checkOutput("io_out", {4'h0, out_port}, 8'h09);
    applyStimulus(8'hB5, 4'h0, 1'b1, "out_im");
    checkOutput("outim_out", {4'h0, out_port}, 8'h05);

    applyStimulus(8'h3F, 4'h0, 1'b1, "set_a");
    applyStimulus(8'h01, 4'h0, 1'b1, "set_c");
    applyStimulus(8'hE7, 4'h0, 1'b1, "jnc_taken_c");
    checkOutput("jnc_c_pc",    {4'h0, pc},    8'h0A);
    checkOutput("jnc_c_carry", {7'h0, carry}, 8'h00);
    applyStimulus(8'hE7, 4'h0, 1'b1, "jnc_nc");
    checkOutput("jnc_nc_pc", {4'h0, pc}, 8'h07);
    applyStimulus(8'hF3, 4'h0, 1'b1, "jmp3");
    for (int i = 0; i < 3; i++) applyStimulus(8'hF3, 4'h0, 1'b1, "jmp_self");
    checkOutput("halt_pc", {4'h0, pc}, 8'h03);

    applyStimulus(8'hF0, 4'h0, 1'b1, "jmp0");
    for (int i = 0; i < 16; i++) applyStimulus(8'h80, 4'($urandom), 1'b1, "nop");
    checkOutput("nop_pc",  {4'h0, pc},       8'h00);
    checkOutput("nop_out", {4'h0, out_port}, 8'h05);

    applyStimulus(8'h35, 4'h0, 1'b1, "mov_a5");
    for (int i = 0; i < 5; i++) applyStimulus(8'h80, 4'h0, 1'b1, "nop_pre_rst");
    checkOutput("pre_rst_pc", {4'h0, pc}, 8'h06);
    async_reset("mid_rst");
    applyStimulus(8'h3C, 4'h0, 1'b1, "restart");

    for (int i = 0; i < 400; i++) begin
      if (i % 40 == 0)
        for (int j = 0; j < 16; j++) rom[j] = 8'($urandom);
      if ($urandom_range(0, 59) == 0) async_reset("rnd_rst");
      applyStimulus(rom[m_pc], 4'($urandom), $urandom_range(0, 3) != 0, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/td4_exec.md
# td4_exec

Single-cycle execute core of the TD4 4-bit CPU. Each enabled clock edge, it decodes the 8-bit instruction word at the current program counter, steers A, B, the input port or zero into the existing 4-bit adder together with the 4-bit immediate, and commits the sum and carry into the register file, output port, carry flag or PC. It sits directly downstream of `adder4`, consuming its sum/carry, and upstream of the program ROM, which it addresses.

## Interface
- No parameters. All widths are fixed by the TD4 ISA: 4-bit data, 4-bit address, 8-bit instruction.
- `clk` — input, 1 — single clock; all state updates on the rising edge.
- `n_reset` — input, 1 — asynchronous, active-low reset.
- `en` — input, 1 — execute enable; when low, all state holds (used for single-step / slow clock).
- `instr` — input, 8 — ROM word at `pc`: `instr[7:4]` is the opcode, `instr[3:0]` is the immediate Im.
- `in_port` — input, 4 — external switch input.
- `pc` — output, 4 — program counter, drives ROM address.
- `out_port` — output, 4 — registered output port.
- `carry` — output, 1 — carry flag register.
- `reg_a` — output, 4 — A register, for debug/bench visibility.
- `reg_b` — output, 4 — B register, for debug/bench visibility.

## Operation
- Adder operands: `a` = source selected by the opcode (A, B, `in_port` or 0); `b` = Im.
- `s` is the result value. `c` is the next carry flag on every executed instruction.
- Opcode map; every executed instruction sets `pc <= pc+1` unless stated otherwise:
  - 0000 ADD A,Im: A <= A+Im.
  - 0001 MOV A,B: A <= B+Im (Im is normally 0).
  - 0010 IN A: A <= in_port+Im.
  - 0011 MOV A,Im: A <= 0+Im.
  - 0100 MOV B,A: B <= A+Im.
  - 0101 ADD B,Im: B <= B+Im.
  - 0110 IN B: B <= in_port+Im.
  - 0111 MOV B,Im: B <= 0+Im.
  - 1001 OUT B: out_port <= B+Im.
  - 1011 OUT Im: out_port <= 0+Im.
  - 1110 JNC Im: if `carry==0` then pc <= Im, else pc <= pc+1. The adder runs on 0+Im, so carry becomes 0.
  - 1111 JMP Im: pc <= Im.
  - 1000, 1010, 1100, 1101: NOP. A, B and out_port hold; carry <= 0; pc <= pc+1.
- JNC tests the carry value held *before* the edge. The carry update and the branch decision are evaluated against the same pre-edge state.
- Arithmetic is modulo 16. The carry flag is bit 4 of the 5-bit sum. PC increment wraps from 15 to 0 with no flag effect.

## Timing
- Reset (async assert, sync-to-clk deassert handled upstream): pc=0, reg_a=0, reg_b=0, out_port=0, carry=0, all immediately on `n_reset` low.
- Latency: one cycle.
  - The instruction presented while `pc`=N is fully committed at the next rising edge with `en`=1.
  - `pc` advances on that same edge, and ROM (combinational) presents the next word in the same cycle.
- `en`=0: no state change, including carry and pc. Outputs are stable.
- Reset mid-program: all state returns to its reset value at once. Execution restarts at address 0 on the first enabled edge after release.
- Simultaneous events:
  - JNC/JMP to the current pc is a legal tight loop (halt idiom).
  - A write to A and a read of A by the same instruction (ADD A,Im) uses the pre-edge A.
- Outputs are all registered. No combinational path from `instr` or `in_port` to any output.

## Structure
- Shared package `td4_pkg` holds:
  - the 4-bit opcode localparams (`OP_ADD_A`, `OP_MOV_AB`, … `OP_JMP`);
  - the source-select encoding (`SRC_A`, `SRC_B`, `SRC_IN`, `SRC_ZERO`);
  - the destination encoding (`DST_A`, `DST_B`, `DST_OUT`, `DST_PC`, `DST_NONE`).
- Sub-module: instantiate the existing `adder4` (ports a, b, s, c) as the datapath adder; do not re-implement addition.
- Decode is a combinational case on the opcode producing src/dst selects. The register/PC/flag update is one always block with the async reset.

## Test plan
- Reset: hold `n_reset`=0 with arbitrary `instr` and clock running -> pc=0, A=B=out_port=0, carry=0. Deassert with `en`=0 for 3 cycles -> nothing changes.
- Arithmetic and carry:
  - MOV A,15 (0x3F) then ADD A,1 (0x01) -> A=0, carry=1, pc=2.
  - Then ADD A,2 -> A=2, carry=0.
- Moves/IO: in_port=0x9; run IN A (0x20), MOV B,A (0x40), OUT B (0x90) -> A=9, B=9, out_port=9, carry=0; OUT Im 0xB5 -> out_port=5.
- Branches:
  - With carry=1, JNC 7 (0xE7) -> pc increments and carry becomes 0.
  - Next JNC 7 -> pc=7.
  - JMP 0xF3 -> pc=3. JMP to its own address holds pc indefinitely.
- Wrap/NOP:
  - 16 consecutive NOPs (0x80) from pc=0 -> pc returns to 0, A/B/out_port unchanged, carry=0.
- Reset mid-program:
  - Assert `n_reset` between edges while A=5, pc=6 -> outputs clear immediately, with no clock edge required.
